// File: rtl/byte_striping_tx_n.sv
// byte_striping_tx_n -- transmit-side byte striper.
// Takes a serial stream of DATA_W-bit words and spreads them round-robin over
// LANES lanes. A stripe is presented on all lanes at once with ready/valid
// backpressure and a per-lane valid mask. A flush emits the current partial
// stripe, and any lanes that were not filled carry PAD.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   in_valid/in_ready   word handshake, in_data carries the word
//   flush               emit the current partial stripe
//   out_valid/out_ready stripe handshake
//   lane_data           lane i at [i*DATA_W +: DATA_W]
//   lane_valid          per-lane valid mask of the presented stripe
//   busy                staging or output register holds data
//   lane_par            (LANE_PARITY_EN only) even parity per lane
//
// Optional feature macro: LANE_PARITY_EN
module byte_striping_tx_n #(
    parameter int                LANES  = 4,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] PAD    = 8'hBC
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] lane_data,
    output logic [LANES-1:0]        lane_valid,
    output logic                    busy
`ifdef LANE_PARITY_EN
    ,
    output logic [LANES-1:0]        lane_par
`endif
);

    localparam int PTR_W = $clog2(LANES);
    localparam int CNT_W = $clog2(LANES + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(LANES - 1);

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    state_t                         state;
    logic [PTR_W-1:0]               ptr;
    logic [LANES-1:0][DATA_W-1:0]   stage;
    logic [LANES-1:0]               hold_mask;
    logic                           flush_pend;

    logic                           acc;
    logic                           out_free;
    logic                           complete;
    logic                           do_flush;
    logic [CNT_W-1:0]               fill_cnt;
    logic [LANES-1:0][DATA_W-1:0]   cand_data;
    logic [LANES-1:0]               cand_mask;
    logic [LANES-1:0][DATA_W-1:0]   ld_data;
    logic [LANES-1:0]               ld_mask;
    logic [LANES-1:0]               ld_par;

    assign in_ready = !reset && (state != HOLD);
    assign acc      = in_valid && in_ready;
    assign out_free = !out_valid || out_ready;
    assign complete = acc && (ptr == LAST);
    // Number of filled lanes once this edge's word (if any) is included.
    assign fill_cnt = CNT_W'(ptr) + CNT_W'(acc);
    // A flush on the completing edge is absorbed by the full stripe.
    assign do_flush = flush && !complete && (fill_cnt != '0);
    assign busy     = (state != IDLE) || out_valid || flush_pend;

    // Candidate stripe: staged words plus the word arriving this edge,
    // unfilled lanes padded. For a completing word every lane is filled.
    always_comb begin
        cand_data = '0;
        cand_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            cand_mask[i] = (CNT_W'(i) < fill_cnt);
            if (acc && (PTR_W'(i) == ptr))
                cand_data[i] = in_data;
            else if (CNT_W'(i) < fill_cnt)
                cand_data[i] = stage[i];
            else
                cand_data[i] = PAD;
        end
    end

    // In HOLD the pending stripe (already padded) sits in stage/hold_mask.
    always_comb begin
        ld_data = (state == HOLD) ? stage : cand_data;
        ld_mask = (state == HOLD) ? hold_mask : cand_mask;
        ld_par  = '0;
        for (int i = 0; i < LANES; i++)
            ld_par[i] = ^ld_data[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            stage      <= '0;
            hold_mask  <= '0;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
            lane_data  <= '0;
            lane_valid <= '0;
`ifdef LANE_PARITY_EN
            lane_par   <= '0;
`endif
        end else begin
            // Consumption; overridden below if a new stripe loads this edge.
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            if (state == HOLD) begin
                if (out_free) begin
                    out_valid  <= 1'b1;
                    lane_data  <= ld_data;
                    lane_valid <= ld_mask;
`ifdef LANE_PARITY_EN
                    lane_par   <= ld_par;
`endif
                    flush_pend <= 1'b0;
                    state      <= IDLE;
                end
            end else if (complete || do_flush) begin
                ptr <= '0;
                if (out_free) begin
                    out_valid  <= 1'b1;
                    lane_data  <= ld_data;
                    lane_valid <= ld_mask;
`ifdef LANE_PARITY_EN
                    lane_par   <= ld_par;
`endif
                    state      <= IDLE;
                end else begin
                    stage      <= cand_data;
                    hold_mask  <= cand_mask;
                    flush_pend <= do_flush;
                    state      <= HOLD;
                end
            end else if (acc) begin
                stage[ptr] <= in_data;
                ptr        <= ptr + 1'b1;
                state      <= FILL;
            end
        end
    end

`ifndef LANE_PARITY_EN
    logic unused_par;
    assign unused_par = ^ld_par;
`endif

endmodule
